instr_rom: RTL and testbench
============================

# instr_rom

Instruction memory for the sequencer core. A host or loader fills it word by word through a write port during an initialisation phase. Once `i_init_done` is asserted the write port is locked and the block serves as a read-only instruction store. The fetch stage reads it with a one-cycle registered read and gets a halt flag that stops fetch before initialisation and past the end of the loaded program.

## Interface
Parameters:
- `ADDR_W`, 12: address width.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 4096: number of words; must equal 2^ADDR_W.

Ports:
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `i_iaddr`  in  ADDR_W  fetch address.
- `o_idata`  out  DATA_W  fetched instruction, registered.
- `o_rom_halt`  out  1  fetch-halt flag, registered.
- `i_wdata`  in  DATA_W  load data.
- `i_we`  in  1  load write enable.
- `i_waddr`  in  ADDR_W  load address.
- `i_init_done`  in  1  level signal; high means loading is finished and writes are locked.

## Operation
- Storage is a DEPTH×DATA_W array, zero at configuration. Reset never clears it.
- Write rule:
  - When `i_we`=1 and `i_init_done`=0, `mem[i_waddr]` takes `i_wdata` at the clock edge.
  - When `i_init_done`=1, all writes are ignored.
- The write path is independent of `i_rst_n`, so loading during reset is legal.
- Program-end tracking:
  - Register `last_addr` (zero at configuration, not reset) holds the highest address written.
  - Flag `loaded` is set on the first accepted write.
  - Both are updated only on accepted writes and are never cleared by reset.
- Read: at each edge out of reset, `o_idata` takes `mem[i_iaddr]`.
- Read/write collision on the same address in the same cycle is read-first: `o_idata` returns the old word.
- Halt: at each edge out of reset, `o_rom_halt` takes `!i_init_done | !loaded | (i_iaddr > last_addr)`.
  - The `(i_iaddr > last_addr)` term is present only when the out-of-range feature is enabled.
- Reads are legal during the load phase; `o_idata` updates but `o_rom_halt` stays 1.

## Timing
- Reset values: `o_idata`=0 and `o_rom_halt`=1. Both take effect immediately on `i_rst_n` falling, with no clock needed.
- After `i_rst_n` rises, the first edge loads real data and halt state.
- Read latency is 1 cycle: an address presented before edge N appears on `o_idata` after edge N.
- Halt latency is also 1 cycle, aligned with the data it qualifies.
- Write latency is 1 cycle: a word written at edge N is readable by an address presented after edge N (visible at edge N+1).
- `i_init_done` takes effect on the same edge: a write with `i_we`=1 in the cycle where `i_init_done` first reads 1 is dropped.
- Address wrap: none. Addresses span exactly 0..DEPTH-1.
- Reset asserted mid-fetch: outputs return to 0/1 asynchronously. Memory, `last_addr` and `loaded` are retained, so fetch resumes without reloading.

## Configuration
- Macro: `INST_ROM_OOR_HALT_EN`.
- Defined: the `last_addr` register is built, and `o_rom_halt` also asserts when `i_iaddr > last_addr`.
- Undefined: `last_addr` is not built, and `o_rom_halt = !i_init_done | !loaded`. Out-of-range fetches return the stored (typically zero) word with no halt.

## Test plan
- Load and read back:
  - Stimulus: with `i_rst_n`=0, write `i+1` to addresses `i`=0..1023; set `i_init_done`=1; release reset; present `i_iaddr`=1, 2, 3, 4, 8, 9, 0x10, 0x12.
  - Required response: one cycle later each, `o_idata` = 2, 3, 4, 5, 9, 10, 0x11, 0x13; `o_rom_halt`=0.
- Halt before init: reset released with `i_init_done`=0 and `i_iaddr`=1 → `o_rom_halt`=1 every cycle until `i_init_done`=1.
- Write lock: after `i_init_done`=1, drive `i_we`=1, `i_waddr`=5, `i_wdata`=0xDEADBEEF; then read address 5 → `o_idata`=6.
- Out-of-range, with macro defined: after the 1024-word load, read address 0x400 → `o_idata`=0 and `o_rom_halt`=1. Read address 0x3FF → 0x400 with `o_rom_halt`=0.
- Async reset mid-fetch: pull `i_rst_n` low between edges while reading address 2 → `o_idata`=0 and `o_rom_halt`=1 before the next edge. After release, reading address 2 returns 3 with no reload.
- Collision: during load, write 0x55 to address 7 while `i_iaddr`=7 → `o_idata` shows the old value that cycle and 0x55 on the next read.

Source files
------------

// File: rtl/instr_rom.sv
// Loadable instruction store: written word by word until i_init_done, then read-only with a registered fetch port.
// Build option INST_ROM_OOR_HALT_EN adds a halt for fetches beyond the highest loaded address.
module instr_rom #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_iaddr,
  output logic [DATA_W-1:0] o_idata,
  output logic              o_rom_halt,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic              i_init_done
);

  // Storage and load-tracking state rely on the zero configuration image; reset never touches them.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              loaded_q;
  logic              loaded_d;
  logic              wr_accept;
  logic              oor_halt;
  logic              halt_d;
  logic [DATA_W-1:0] idata_q;
  logic              halt_q;

  assign wr_accept = i_we & ~i_init_done;
  assign loaded_d  = loaded_q | wr_accept;

  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem_q[i_waddr] <= i_wdata;
    end
    loaded_q <= loaded_d;
  end

`ifdef INST_ROM_OOR_HALT_EN
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] last_addr_d;

  always_comb begin
    last_addr_d = last_addr_q;
    if (wr_accept && (!loaded_q || (i_waddr > last_addr_q))) begin
      last_addr_d = i_waddr;
    end
  end

  always_ff @(posedge i_clk) begin
    last_addr_q <= last_addr_d;
  end

  assign oor_halt = (i_iaddr > last_addr_q);
`else
  assign oor_halt = 1'b0;
`endif

  assign halt_d = ~i_init_done | ~loaded_q | oor_halt;

  // Read-first: a same-cycle write to i_iaddr is not forwarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idata_q <= '0;
      halt_q  <= 1'b1;
    end else begin
      idata_q <= mem_q[i_iaddr];
      halt_q  <= halt_d;
    end
  end

  assign o_idata    = idata_q;
  assign o_rom_halt = halt_q;

endmodule

// File: tb/tb_instr_rom.sv
// Self-checking bench for instr_rom: directed load/lock/reset scenarios plus randomized traffic
// compared against an array-based model of the load and fetch rules.
module tb_instr_rom;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
`ifdef INST_ROM_OOR_HALT_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] idata;
  logic              rom_halt;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              init_done;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_loaded;
  int                ref_last;

  instr_rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_iaddr     (iaddr),
    .o_idata     (idata),
    .o_rom_halt  (rom_halt),
    .i_wdata     (wdata),
    .i_we        (we),
    .i_waddr     (waddr),
    .i_init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: predict from current inputs and model state, update the model, then compare after the edge.
  task automatic cycle(input string tag, input bit verbose);
    logic [31:0] exp_d;
    logic [31:0] exp_h;
    if (!rst_n) begin
      exp_d = '0;
      exp_h = 32'd1;
    end else begin
      exp_d = ref_mem[iaddr];
      exp_h = (!init_done || !ref_loaded || (OOR_EN && (int'(iaddr) > ref_last))) ? 32'd1 : 32'd0;
    end
    if (we && !init_done) begin
      ref_mem[waddr] = wdata;
      if (!ref_loaded || int'(waddr) > ref_last) ref_last = int'(waddr);
      ref_loaded = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_data"}, idata, exp_d);
    check_eq({tag, "_halt"}, 32'(rom_halt), exp_h);
    if (verbose)
      $display("[TB] %s rst_n=%b init=%b we=%b waddr=%h iaddr=%h -> data=%h halt=%b",
               tag, rst_n, init_done, we, waddr, iaddr, idata, rom_halt);
  endtask

  initial begin
    int rd_list [8] = '{1, 2, 3, 4, 8, 9, 'h10, 'h12};
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_loaded = 1'b0;
    ref_last   = 0;

    rst_n = 1'b1; iaddr = '0; we = 1'b0; waddr = '0; wdata = '0; init_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_async_data", idata, 32'd0);
    check_eq("reset_async_halt", 32'(rom_halt), 32'd1);
    $display("[TB] reset asserted: data=%h halt=%b", idata, rom_halt);

    // Load 1024 words while reset is held
    for (int i = 0; i < 1024; i++) begin
      we = 1'b1; waddr = 12'(i); wdata = 32'(i + 1); iaddr = 12'(i);
      cycle("load_in_reset", i == 0 || i == 1023);
    end
    we = 1'b0;

    rst_n = 1'b1;
    iaddr = 12'd1;
    repeat (4) cycle("halt_pre_init", 1'b1);

    we = 1'b1; waddr = 12'd7; wdata = 32'h55; iaddr = 12'd7;
    cycle("collide_old", 1'b1);
    we = 1'b0;
    cycle("collide_new", 1'b1);

    // Randomized load traffic that leaves the low addresses and the top word untouched
    repeat (200) begin
      we    = 1'($urandom_range(0, 1));
      waddr = 12'($urandom_range(20, 1000));
      wdata = $urandom;
      iaddr = 12'($urandom_range(0, 1100));
      cycle("rand_load", 1'b0);
    end

    // Write in the very cycle init_done rises must be dropped
    init_done = 1'b1; we = 1'b1; waddr = 12'd6; wdata = 32'hBAD0BAD0; iaddr = 12'd6;
    cycle("init_edge_drop", 1'b1);
    we = 1'b0;
    cycle("init_edge_read", 1'b1);

    foreach (rd_list[k]) begin
      iaddr = 12'(rd_list[k]);
      cycle("plan_read", 1'b1);
    end

    we = 1'b1; waddr = 12'd5; wdata = 32'hDEADBEEF; iaddr = 12'd0;
    cycle("lock_write", 1'b1);
    we = 1'b0; iaddr = 12'd5;
    cycle("lock_read", 1'b1);

    iaddr = 12'h400;
    cycle("oor_read", 1'b1);
    iaddr = 12'h3FF;
    cycle("last_read", 1'b1);

    // Reset pulled between edges while fetching address 2
    iaddr = 12'd2;
    cycle("pre_reset_fetch", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midfetch_reset_data", idata, 32'd0);
    check_eq("midfetch_reset_halt", 32'(rom_halt), 32'd1);
    $display("[TB] mid-fetch reset: data=%h halt=%b", idata, rom_halt);
    cycle("held_reset", 1'b1);
    rst_n = 1'b1;
    cycle("resume_fetch", 1'b1);

    // Randomized locked-phase traffic with occasional reset pulses
    repeat (300) begin
      rst_n = ($urandom_range(0, 19) != 0);
      we    = 1'($urandom_range(0, 1));
      waddr = 12'($urandom);
      wdata = $urandom;
      iaddr = 12'($urandom_range(0, 1200));
      cycle("rand_locked", 1'b0);
    end
    rst_n = 1'b1;
    we    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
